// File: rtl/wb_pingpong_buffer.sv
// Two-entry ping-pong FIFO between a write-back producer and the response arbiter.
// wr_ready depends only on stored occupancy, so rd_ready never reaches the producer combinationally.
module wb_pingpong_buffer #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_wb_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_wb_data
);

    logic [1:0][DW-1:0] entry;
    logic               wp;
    logic               rp;
    logic [1:0]         cnt;
    logic               wr_fire;
    logic               rd_fire;

    assign wr_ready   = (cnt != 2'd2);
    assign rd_valid   = (cnt != 2'd0);
    assign rd_wb_data = entry[rp];
    assign wr_fire    = wr_valid & wr_ready;
    assign rd_fire    = rd_valid & rd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry <= '0;
            wp    <= 1'b0;
            rp    <= 1'b0;
            cnt   <= 2'd0;
        end else begin
            if (wr_fire) begin
                entry[wp] <= wr_wb_data;
                wp        <= ~wp;
            end
            if (rd_fire)
                rp <= ~rp;
            // Simultaneous write and read leaves occupancy unchanged.
            case ({wr_fire, rd_fire})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_pingpong_buffer.sv
// Randomized self-checking bench for wb_pingpong_buffer against a queue-based FIFO model.
module tb_wb_pingpong_buffer;

    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_wb_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_wb_data;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_q[$];

    wb_pingpong_buffer #(.DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_wb_data (wr_wb_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_wb_data (rd_wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; the model is a two-deep FIFO queue updated from the current inputs.
    task automatic tick();
        bit wf;
        bit rf;
        logic [DW-1:0] d;
        wf = wr_valid && (model_q.size() < 2) && rst_n;
        rf = rd_ready && (model_q.size() > 0) && rst_n;
        d  = wr_wb_data;
        @(posedge clk);
        if (rf) void'(model_q.pop_front());
        if (wf) model_q.push_back(d);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_wb_data = '0;
        model_q.delete();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rd_valid !== 1'b0 || wr_ready !== 1'b1 || rd_wb_data !== '0) begin
            errors++;
            $display("FAIL reset_held: rd_valid=%0b wr_ready=%0b data=%h, need 0 1 0", rd_valid, wr_ready, rd_wb_data);
        end
        rst_n = 1'b1;
        rd_ready = 1'b1;
        repeat (4) begin
            tick();
            checks++;
            if (rd_valid !== 1'b0 || wr_ready !== 1'b1 || rd_wb_data !== '0) begin
                errors++;
                $display("FAIL reset_idle: rd_valid=%0b wr_ready=%0b data=%h, need 0 1 0", rd_valid, wr_ready, rd_wb_data);
            end
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_single();
        wr_valid = 1'b1; wr_wb_data = 32'hDEADBEEF; rd_ready = 1'b0;
        tick();
        wr_valid = 1'b0; wr_wb_data = 32'h0BAD0BAD;
        repeat (3) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_wb_data !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL single_stall: rd_valid=%0b data=%h, need 1 deadbeef", rd_valid, rd_wb_data);
            end
            tick();
        end
        rd_ready = 1'b1;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_drain: rd_valid=%0b wr_ready=%0b, need 0 1", rd_valid, wr_ready);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_fill_stall();
        rd_ready = 1'b0; wr_valid = 1'b1;
        wr_wb_data = 32'h11; tick();
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_one_ready: wr_ready=%0b, need 1", wr_ready);
        end
        wr_wb_data = 32'h22; tick();
        wr_wb_data = 32'h33;
        checks++;
        if (wr_ready !== 1'b0 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: wr_ready=%0b rd_valid=%0b, need 0 1", wr_ready, rd_valid);
        end
        tick();
        tick();
        wr_valid = 1'b0;
        checks++;
        if (rd_wb_data !== 32'h11 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_head: data=%h wr_ready=%0b, need 11 0", rd_wb_data, wr_ready);
        end
        // Reading while full must not raise wr_ready in the same cycle.
        rd_ready = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_no_comb_ready: wr_ready=%0b, need 0", wr_ready);
        end
        tick();
        checks++;
        if (wr_ready !== 1'b1 || rd_valid !== 1'b1 || rd_wb_data !== 32'h22) begin
            errors++;
            $display("FAIL fill_second: wr_ready=%0b rd_valid=%0b data=%h, need 1 1 22", wr_ready, rd_valid, rd_wb_data);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0 || model_q.size() != 0) begin
            errors++;
            $display("FAIL fill_empty: rd_valid=%0b model_size=%0d, need 0 0 (0x33 must be dropped)", rd_valid, model_q.size());
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_streaming();
        logic [DW-1:0] got[$];
        int cyc = 0;
        wr_valid = 1'b1; rd_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            wr_wb_data = DW'(i);
            checks++;
            if (wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready: word %0d wr_ready=%0b, need 1", i, wr_ready);
            end
            if (rd_valid === 1'b1) got.push_back(rd_wb_data);
            tick();
        end
        wr_valid = 1'b0;
        while (got.size() < 16 && cyc < 10) begin
            if (rd_valid === 1'b1) got.push_back(rd_wb_data);
            tick();
            cyc++;
        end
        checks++;
        if (got.size() != 16) begin
            errors++;
            $display("FAIL stream_count: got %0d words, need 16", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== DW'(i + 1)) begin
                errors++;
                $display("FAIL stream_order: idx %0d data=%h, need %h", i, got[i], DW'(i + 1));
            end
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_random();
        int written = 0;
        int cyc = 0;
        int bad = 0;
        while ((written < 200 || model_q.size() != 0) && cyc < 5000) begin
            wr_valid   = (written < 200) && ($urandom_range(0, 3) != 0);
            rd_ready   = ($urandom_range(0, 2) != 0);
            wr_wb_data = $urandom;
            #1;
            checks++;
            if (rd_valid !== (model_q.size() != 0) || wr_ready !== (model_q.size() != 2) ||
                (model_q.size() != 0 && rd_wb_data !== model_q[0])) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_cycle %0d: rd_valid=%0b wr_ready=%0b data=%h, need %0b %0b %h",
                             cyc, rd_valid, wr_ready, rd_wb_data, model_q.size() != 0,
                             model_q.size() != 2, (model_q.size() != 0) ? model_q[0] : '0);
            end
            if (wr_valid && model_q.size() < 2) written++;
            tick();
            cyc++;
        end
        checks++;
        if (cyc >= 5000) begin
            errors++;
            $display("FAIL random_timeout: %0d words written, %0d left in model", written, model_q.size());
        end
        wr_valid = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        wr_valid = 1'b1; rd_ready = 1'b0;
        wr_wb_data = 32'hAAAA0001; tick();
        wr_wb_data = 32'hAAAA0002; tick();
        wr_valid = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL areset_prefill: rd_valid=%0b wr_ready=%0b, need 1 0", rd_valid, wr_ready);
        end
        #2;
        rst_n = 1'b0;
        model_q.delete();
        #1;
        checks++;
        if (rd_valid !== 1'b0 || wr_ready !== 1'b1 || rd_wb_data !== '0) begin
            errors++;
            $display("FAIL areset_immediate: rd_valid=%0b wr_ready=%0b data=%h, need 0 1 0", rd_valid, wr_ready, rd_wb_data);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wr_valid = 1'b1; wr_wb_data = 32'h000000A5;
        tick();
        wr_valid = 1'b1; wr_wb_data = 32'h000000B6;
        tick();
        wr_valid = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_wb_data !== 32'h000000A5) begin
            errors++;
            $display("FAIL areset_first_after: rd_valid=%0b data=%h, need 1 000000a5", rd_valid, rd_wb_data);
        end
        rd_ready = 1'b1;
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_wb_data !== 32'h000000B6) begin
            errors++;
            $display("FAIL areset_second_after: rd_valid=%0b data=%h, need 1 000000b6", rd_valid, rd_wb_data);
        end
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_stall();
        test_streaming();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
